// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared MDOp encodings for the multiply/divide unit and the control decoder
package muldiv_unit_pkg;
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } mdOp_e;
endpackage

// File: rtl/md_divider.sv
// md_divider: combinational signed/unsigned 32-bit quotient and remainder
//   dividend, divisor : operands
//   isSigned          : treat operands as two's complement
//   quotient          : truncated toward zero
//   remainder         : carries the sign of the dividend
//   divByZero         : divisor is zero; quotient/remainder forced to 0
module md_divider (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        isSigned,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        divByZero
);
    logic        negA, negB, overflow;
    logic [31:0] magA, magB, safeB, magQ, magR;
    always_comb begin
        negA      = isSigned & dividend[31];
        negB      = isSigned & divisor[31];
        magA      = negA ? -dividend : dividend;
        magB      = negB ? -divisor : divisor;
        divByZero = divisor == 32'd0;
        // most-negative / -1 cannot be represented; MIPS leaves it wrapped, no trap
        overflow  = isSigned && dividend == 32'h8000_0000 && divisor == 32'hFFFF_FFFF;
        // keep the divider datapath away from a zero divisor
        safeB     = divByZero ? 32'd1 : magB;
        magQ      = magA / safeB;
        magR      = magA % safeB;
        quotient  = divByZero ? 32'd0 : overflow ? 32'h8000_0000 : (negA ^ negB) ? -magQ : magQ;
        remainder = (divByZero || overflow) ? 32'd0 : negA ? -magR : magR;
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: execute-stage multi-cycle multiply/divide unit owning HI/LO
//   clk   : core clock
//   reset : synchronous active-high, clears all state and aborts any op
//   Start : one-cycle request from E stage (ignored while Busy)
//   MDOp  : 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no effect
//   A, B  : forwarded rs / rt operands
//   Busy  : long operation in flight (registered)
//   HI,LO : architectural registers, plain register outputs
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1) < 4 ? 4 : $clog2(MAXC + 1);

    logic [CW-1:0] cnt, cntNext;
    logic [31:0]   pendHi, pendLo, quo, rem;
    logic [63:0]   aExt, bExt, product;
    logic          pendWrite, idleStart, isMul, isDiv, isSignedOp, divByZero;

    md_divider uDiv (
        .dividend (A),
        .divisor  (B),
        .isSigned (isSignedOp),
        .quotient (quo),
        .remainder(rem),
        .divByZero(divByZero)
    );

    always_comb begin
        idleStart  = Start && cnt == '0;
        isMul      = MDOp == MD_MULT || MDOp == MD_MULTU;
        isDiv      = MDOp == MD_DIV || MDOp == MD_DIVU;
        isSignedOp = MDOp == MD_MULT || MDOp == MD_DIV;
        aExt       = {{32{isSignedOp & A[31]}}, A};
        bExt       = {{32{isSignedOp & B[31]}}, B};
        // low 64 bits of the extended product are exact for both signednesses
        product    = aExt * bExt;
        cntNext    = cnt != '0 ? cnt - CW'(1) :
                     (idleStart && isMul) ? CW'(MULT_CYCLES) :
                     (idleStart && isDiv) ? CW'(DIV_CYCLES) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            Busy      <= 1'b0;
            HI        <= '0;
            LO        <= '0;
            pendHi    <= '0;
            pendLo    <= '0;
            pendWrite <= 1'b0;
        end else begin
            cnt  <= cntNext;
            Busy <= cntNext != '0;
            if (idleStart && isMul) begin
                {pendHi, pendLo} <= product;
                pendWrite        <= 1'b1;
            end else if (idleStart && isDiv) begin
                pendHi    <= rem;
                pendLo    <= quo;
                pendWrite <= !divByZero;
            end
            if (idleStart && MDOp == MD_MTHI) HI <= A;
            if (idleStart && MDOp == MD_MTLO) LO <= A;
            if (cnt == CW'(1) && pendWrite) begin
                HI <= pendHi;
                LO <= pendLo;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  MDOp = 3'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy;
    logic [31:0] HI, LO;
    int          total = 0;
    int          bad = 0;

    muldiv_unit dut (
        .clk  (clk),
        .reset(reset),
        .Start(Start),
        .MDOp (MDOp),
        .A    (A),
        .B    (B),
        .Busy (Busy),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        step();
        Start = 1'b0;
        A     = '0;
        B     = '0;
    endtask

    // n busy cycles with HI/LO held, then Busy low and the new values
    task automatic waitDone(input string tag, input int n,
                            input logic [31:0] oldHi, input logic [31:0] oldLo,
                            input logic [31:0] newHi, input logic [31:0] newLo);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, 32'(Busy), 32'd1);
            check({tag, "_holdHi"}, HI, oldHi);
            check({tag, "_holdLo"}, LO, oldLo);
            step();
        end
        check({tag, "_idle"}, 32'(Busy), 32'd0);
        check({tag, "_hi"}, HI, newHi);
        check({tag, "_lo"}, LO, newLo);
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        waitDone("mult", 5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h0000_0001);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        waitDone("div", 10, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(MD_DIVU, 32'hFFFF_FFF9, 32'd2);
        waitDone("divu", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'h7FFF_FFFC);

        issue(MD_MTHI, 32'h11, 32'd0);
        issue(MD_MTLO, 32'h22, 32'd0);
        check("pre_hi", HI, 32'h11);
        check("pre_lo", LO, 32'h22);
        issue(MD_DIV, 32'd100, 32'd0);
        waitDone("div0", 10, 32'h11, 32'h22, 32'h11, 32'h22);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone("divovf", 10, 32'h11, 32'h22, 32'd0, 32'h8000_0000);

        issue(MD_MTHI, 32'h1234, 32'd0);
        check("mthi_hi", HI, 32'h1234);
        check("mthi_busy", 32'(Busy), 32'd0);
        issue(MD_MTLO, 32'h5678, 32'd0);
        check("mtlo_lo", LO, 32'h5678);
        check("mtlo_hi", HI, 32'h1234);
        check("mtlo_busy", 32'(Busy), 32'd0);

        issue(MD_MULT, 32'd2, 32'd3);
        check("ign_busy", 32'(Busy), 32'd1);
        issue(MD_MTLO, 32'hDEAD, 32'd0);
        waitDone("ign", 4, 32'h1234, 32'h5678, 32'd0, 32'd6);

        issue(MD_DIV, 32'd100, 32'd7);
        check("abort_b1", 32'(Busy), 32'd1);
        step();
        check("abort_b2", 32'(Busy), 32'd1);
        step();
        check("abort_b3", 32'(Busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        for (int i = 0; i < 12; i++) step();
        check("abort_late_busy", 32'(Busy), 32'd0);
        check("abort_late_hi", HI, 32'd0);
        check("abort_late_lo", LO, 32'd0);
        issue(MD_MULT, 32'd7, 32'd6);
        waitDone("postrst", 5, 32'd0, 32'd0, 32'd0, 32'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
